chip8_fb_scanout: RTL and testbench

Display-side reader for the CHIP-8 64x32 monochrome framebuffer. The CPU core writes the framebuffer through DXYN/00E0; this block reads it back one row at a time and produces a 640x480@60 VGA-style pixel stream with integer scaling and a vertical letterbox. It also emits a once-per-frame tick that the core uses as its 60 Hz delay/sound timer strobe.

---
 rtl/chip8_pkg.sv | 26 ++
 rtl/chip8_fb_scanout_if.sv | 9 +
 rtl/chip8_vga_timing.sv | 77 +++++++
 rtl/chip8_fb_scanout.sv | 123 ++++++++++++
 tb/tb_chip8_fb_scanout.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/chip8_pkg.sv
// Shared constants and types for the CHIP-8 framebuffer scanout: framebuffer geometry
// and the default 640x480@60 raster timing.
package chip8_pkg;
  localparam int CHIP8_W = 64;
  localparam int CHIP8_H = 32;
  localparam int ROW_AW  = 5;
  localparam int COL_W   = 6;
  localparam int CNT_W   = 10;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  typedef logic [CNT_W-1:0]   cnt_t;
  typedef logic [CHIP8_W-1:0] row_t;
  typedef logic [ROW_AW-1:0]  row_addr_t;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/chip8_fb_scanout_if.sv
// Row-read port between the scanout reader (master) and the framebuffer RAM (slave).
interface chip8_fb_scanout_if;
  import chip8_pkg::*;
  logic      fb_rd;
  row_addr_t fb_addr;
  row_t      fb_data;
  modport master (output fb_rd, fb_addr, input fb_data);
  modport slave  (input fb_rd, fb_addr, output fb_data);
endinterface

// File: rtl/chip8_vga_timing.sv
// Pixel-enable divider and raster counters; registered sync/de plus the per-line
// fetch point, end-of-line step and once-per-frame tick.
module chip8_vga_timing
  import chip8_pkg::*;
#(
  parameter int CE_DIV   = 5,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic clk,
  input  logic reset,
  output logic ce,
  output logic line_end,
  output logic fetch_pt,
  output cnt_t h_cnt,
  output cnt_t v_cnt,
  output logic hsync,
  output logic vsync,
  output logic de,
  output logic frame_tick
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = clog2_min1(CE_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CE_DIV - 1);
  localparam cnt_t H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam cnt_t V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam cnt_t H_ACT    = CNT_W'(H_ACTIVE);
  localparam cnt_t V_ACT    = CNT_W'(V_ACTIVE);
  localparam cnt_t V_ACT_LST = CNT_W'(V_ACTIVE - 1);
  localparam cnt_t HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
  localparam cnt_t HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam cnt_t VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
  localparam cnt_t VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div;
  logic             h_last;

  assign ce       = (div == DIV_LAST);
  assign h_last   = (h_cnt == H_LAST);
  assign line_end = ce && h_last;
  assign fetch_pt = ce && (h_cnt == H_ACT);

  // Video outputs are decoded from the pre-increment counters, giving one pixel of lag.
  always_ff @(posedge clk) begin
    if (reset) begin
      div        <= '0;
      h_cnt      <= '0;
      v_cnt      <= '0;
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      de         <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      div        <= ce ? '0 : div + 1'b1;
      frame_tick <= line_end && (v_cnt == V_ACT_LST);
      if (ce) begin
        hsync <= !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
        vsync <= !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
        de    <= (h_cnt < H_ACT) && (v_cnt < V_ACT);
        if (h_last) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/chip8_fb_scanout.sv
// CHIP-8 framebuffer scanout: fetches one 64-bit row per display line into a line
// buffer and scales it into the letterboxed raster produced by chip8_vga_timing.
module chip8_fb_scanout
  import chip8_pkg::*;
#(
  parameter int CE_DIV   = 5,
  parameter int SCALE    = 10,
  parameter int Y_OFFSET = 80,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic               clk,
  input  logic               reset,
  chip8_fb_scanout_if.master fb,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic               pixel,
  output logic               frame_tick
);
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int SUB_W   = clog2_min1(SCALE);

  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SCALE - 1);
  localparam row_addr_t ROW_LAST = ROW_AW'(CHIP8_H - 1);
  localparam cnt_t H_ACT   = CNT_W'(H_ACTIVE);
  localparam cnt_t V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam cnt_t WIN_TOP = CNT_W'(Y_OFFSET);
  // Line whose fetch slot loads row 0; wraps to the last line when the window starts at 0.
  localparam cnt_t PRE_TOP = (Y_OFFSET == 0) ? CNT_W'(V_TOTAL - 1) : CNT_W'(Y_OFFSET - 1);

  logic ce, line_end, fetch_pt;
  cnt_t h_cnt, v_cnt, next_v;

  chip8_vga_timing #(
    .CE_DIV(CE_DIV), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk(clk), .reset(reset), .ce(ce), .line_end(line_end), .fetch_pt(fetch_pt),
    .h_cnt(h_cnt), .v_cnt(v_cnt), .hsync(hsync), .vsync(vsync), .de(de),
    .frame_tick(frame_tick)
  );

  logic             in_win, pre_top, last_line, fetch_en, rd_d;
  row_addr_t        win_row, fetch_row;
  logic [SUB_W-1:0] win_sub, sub_col;
  logic [COL_W-1:0] col;
  row_t             line_buf;

  always_comb begin
    next_v    = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    pre_top   = (v_cnt == PRE_TOP);
    last_line = (win_row == ROW_LAST) && (win_sub == SUB_LAST);
    fetch_en  = pre_top || (in_win && !last_line);
    fetch_row = win_row;
    if (pre_top)                fetch_row = '0;
    else if (win_sub == SUB_LAST) fetch_row = win_row + 1'b1;
  end

  // Window position of the current line; advanced at end of line, ahead of the next one.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_win  <= 1'b0;
      win_row <= '0;
      win_sub <= '0;
    end else if (line_end) begin
      if (next_v == WIN_TOP) begin
        in_win  <= 1'b1;
        win_row <= '0;
        win_sub <= '0;
      end else if (in_win) begin
        if (win_sub == SUB_LAST) begin
          win_sub <= '0;
          win_row <= win_row + 1'b1;
          if (win_row == ROW_LAST) in_win <= 1'b0;
        end else begin
          win_sub <= win_sub + 1'b1;
        end
      end
    end
  end

  // The row is fetched during horizontal blanking of the preceding line, so the line
  // buffer is a stable snapshot for the whole of the line it feeds.
  always_ff @(posedge clk) begin
    if (reset) begin
      fb.fb_rd   <= 1'b0;
      fb.fb_addr <= '0;
      rd_d       <= 1'b0;
      line_buf   <= '0;
    end else begin
      fb.fb_rd <= fetch_pt && fetch_en;
      if (fetch_pt && fetch_en) fb.fb_addr <= fetch_row;
      rd_d <= fb.fb_rd;
      if (rd_d) line_buf <= fb.fb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col     <= '0;
      sub_col <= '0;
      pixel   <= 1'b0;
    end else if (ce) begin
      pixel <= in_win && (h_cnt < H_ACT) && line_buf[~col];
      if (line_end) begin
        col     <= '0;
        sub_col <= '0;
      end else if (sub_col == SUB_LAST) begin
        sub_col <= '0;
        col     <= col + 1'b1;
      end else begin
        sub_col <= sub_col + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_chip8_fb_scanout.sv
// Scoreboard bench on a shrunken raster (2 clk/pixel, 2x scale, 136x71 total) so that
// several full frames fit in a short run; expectations are queued ahead of the monitor.
module tb_chip8_fb_scanout;
  localparam int CE = 2, SC = 2, YO = 2;
  localparam int HA = 128, HF = 2, HS = 4, HB = 2, HT = HA + HF + HS + HB;  // 136
  localparam int VA = 68,  VF = 1, VS = 1, VB = 1, VT = VA + VF + VS + VB;  // 71
  localparam int FRAME = CE * HT * VT;                                      // 19312 clks

  localparam logic [63:0] R0   = 64'h8000_0000_0000_0001;
  localparam logic [63:0] R5A  = 64'hFF00_0000_0000_0000;
  localparam logic [63:0] R5B  = 64'h0000_0000_0000_00FF;
  localparam logic [63:0] R10  = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] ONES = '1;

  typedef struct { int clk; logic [4:0] addr; } fetch_t;
  typedef struct { int hs_n; int hs0; int vs_n; int de_n; logic [HA-1:0] pix; } line_t;

  logic clk = 1'b0, reset = 1'b1;
  logic hsync, vsync, de, pixel, frame_tick;
  logic [63:0] mem [32];
  int clk_n = 0, n_vec = 0, n_bad = 0;
  bit run_mon = 1'b0;

  fetch_t exp_fetch[$];
  int     exp_tick[$];
  line_t  exp_line[$];

  chip8_fb_scanout_if fb();

  chip8_fb_scanout #(
    .CE_DIV(CE), .SCALE(SC), .Y_OFFSET(YO),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .reset(reset), .fb(fb), .hsync(hsync), .vsync(vsync), .de(de),
    .pixel(pixel), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk) clk_n <= reset ? 0 : clk_n + 1;

  // Framebuffer with one-clk read latency
  always @(posedge clk) if (fb.fb_rd) fb.fb_data <= mem[fb.fb_addr];

  task automatic chk(input string name, input int tag, input logic [127:0] act,
                     input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s [%0d]: got %0h expected %0h", name, tag, act, exp);
    end
  endtask

  task automatic miss(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: unexpected event at clk %0d", name, clk_n);
  endtask

  function automatic logic [63:0] row_data(input int v, input int cf);
    int r;
    r = (v - YO) / SC;
    case (r)
      0:       return R0;
      5:       return (cf == 0 && v == YO + 5 * SC) ? R5A : R5B;
      10:      return R10;
      31:      return ONES;
      default: return '0;
    endcase
  endfunction

  function automatic logic [HA-1:0] expand(input logic [63:0] r);
    logic [HA-1:0] x;
    for (int c = 0; c < 64; c++)
      for (int s = 0; s < SC; s++) x[c * SC + s] = r[63 - c];
    return x;
  endfunction

  // cf selects which framebuffer contents the frame sees (row 5 changes in frame 0).
  task automatic push_frame(input int base, input int cf);
    line_t  e;
    fetch_t f;
    for (int v = 0; v < VT; v++) begin
      e.hs_n = HS;
      e.hs0  = HA + HF;
      e.vs_n = (v >= VA + VF && v < VA + VF + VS) ? HT : 0;
      e.de_n = (v < VA) ? HA : 0;
      e.pix  = (v >= YO && v < YO + 32 * SC) ? expand(row_data(v, cf)) : '0;
      exp_line.push_back(e);
    end
    for (int k = 0; k < 32 * SC; k++) begin
      f.clk  = base + CE * ((YO - 1 + k) * HT + HA + 1);
      f.addr = 5'(k / SC);
      exp_fetch.push_back(f);
    end
    exp_tick.push_back(base + CE * VA * HT);
  endtask

  task automatic wait_clk(input int n);
    int i;
    for (i = 0; i < 100000 && clk_n != n; i++) @(negedge clk);
    if (clk_n != n) chk("wait_timeout", n, 128'(clk_n), 128'(n));
  endtask

  task automatic chk_reset_vals(input int tag);
    chk("rst_hsync", tag, 128'(hsync), 128'(1));
    chk("rst_vsync", tag, 128'(vsync), 128'(1));
    chk("rst_de", tag, 128'(de), 128'(0));
    chk("rst_pixel", tag, 128'(pixel), 128'(0));
    chk("rst_fb_rd", tag, 128'(fb.fb_rd), 128'(0));
    chk("rst_fb_addr", tag, 128'(fb.fb_addr), 128'(0));
    chk("rst_tick", tag, 128'(frame_tick), 128'(0));
  endtask

  int acc_hs, acc_hs0, acc_vs, acc_de, acc_oob, line_no, mp, mh;
  logic [HA-1:0] acc_pix;
  fetch_t mf;
  line_t  ml;
  int     mt;

  always @(negedge clk) begin
    if (reset) begin
      acc_hs = 0; acc_hs0 = -1; acc_vs = 0; acc_de = 0; acc_oob = 0; acc_pix = '0;
    end else if (run_mon) begin
      if (fb.fb_rd) begin
        if (exp_fetch.size() == 0) miss("fetch_extra");
        else begin
          mf = exp_fetch.pop_front();
          chk("fetch_clk", mf.clk, 128'(clk_n), 128'(mf.clk));
          chk("fetch_addr", mf.clk, 128'(fb.fb_addr), 128'(mf.addr));
        end
      end
      if (frame_tick) begin
        if (exp_tick.size() == 0) miss("tick_extra");
        else begin
          mt = exp_tick.pop_front();
          chk("tick_clk", mt, 128'(clk_n), 128'(mt));
        end
      end
      // Outputs registered from raster position mp appear after clk CE*(mp+1)
      if (clk_n > 0 && clk_n % CE == 0) begin
        mp = clk_n / CE - 1;
        mh = mp % HT;
        if (!hsync) begin
          if (acc_hs == 0) acc_hs0 = mh;
          acc_hs++;
        end
        if (!vsync) acc_vs++;
        if (de) acc_de++;
        if (pixel && !de) acc_oob++;
        if (mh < HA) acc_pix[mh] = pixel;
        if (mh == HT - 1) begin
          line_no = (mp / HT) % VT;
          if (exp_line.size() == 0) miss("line_extra");
          else begin
            ml = exp_line.pop_front();
            chk("hsync_len", line_no, 128'(acc_hs), 128'(ml.hs_n));
            chk("hsync_start", line_no, 128'(acc_hs0), 128'(ml.hs0));
            chk("vsync_len", line_no, 128'(acc_vs), 128'(ml.vs_n));
            chk("de_len", line_no, 128'(acc_de), 128'(ml.de_n));
            chk("pixel_oob", line_no, 128'(acc_oob), 128'(0));
            chk("pixels", line_no, 128'(acc_pix), 128'(ml.pix));
          end
          acc_hs = 0; acc_hs0 = -1; acc_vs = 0; acc_de = 0; acc_oob = 0; acc_pix = '0;
        end
      end
    end
  end

  initial begin
    for (int r = 0; r < 32; r++) mem[r] = '0;
    mem[0] = R0; mem[5] = R5A; mem[10] = R10; mem[31] = ONES;
    push_frame(0, 0);
    push_frame(FRAME, 1);
    run_mon = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals(0);
    reset = 1'b0;
    // Divider reaches CE-1 after one clk; first raster update is on the next clk
    @(negedge clk);
    chk("pre_ce_de", clk_n, 128'(de), 128'(0));
    chk("pre_ce_hsync", clk_n, 128'(hsync), 128'(1));
    @(negedge clk);
    chk("first_ce_de", clk_n, 128'(de), 128'(1));

    // Row 5 fetched for line 12 at clk 3250, captured at 3252; change it one clk later
    wait_clk(CE * (11 * HT + HA + 1) + 3);
    mem[5] = R5B;

    wait_clk(2 * FRAME + 1);
    run_mon = 1'b0;
    chk("fetch_left", 1, 128'(exp_fetch.size()), 128'(0));
    chk("tick_left", 1, 128'(exp_tick.size()), 128'(0));
    chk("line_left", 1, 128'(exp_line.size()), 128'(0));

    // Reset pulsed mid-frame at v=20, h=30 of the third frame
    wait_clk(2 * FRAME + CE * (20 * HT + 30));
    reset = 1'b1;
    push_frame(0, 1);
    run_mon = 1'b1;
    @(negedge clk);
    chk_reset_vals(1);
    reset = 1'b0;
    wait_clk(FRAME + 2);
    chk("fetch_left", 2, 128'(exp_fetch.size()), 128'(0));
    chk("tick_left", 2, 128'(exp_tick.size()), 128'(0));
    chk("line_left", 2, 128'(exp_line.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
